sa_ctrl: RTL
============

Name: sa_ctrl

Overview:
- Sequencing controller for a ROWS x COLS systolic array of PEs.
- Drives the array-wide operation code that all PEs share, the array clear, and the read/write strobes and addresses for the weight, activation and result buffers.
- Supports two dataflows per job: weight-stationary (load, then flow) and output-stationary (clear, flow, then drain).
- Sits between the host command interface and the array and skew buffers.

Parameters:
- ROWS, 4, array rows.
- COLS, 4, array columns.
- CNT_WIDTH, 8, width of k_len and of all buffer address counters.
- OP_SIG_WIDTH, 3, width of the PE operation code.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- mode  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS); latched on accepted start.
- k_len  in  CNT_WIDTH  reduction length (number of activation vectors); latched on accepted start.
- busy  out  1  high from the first cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle completion pulse.
- cfg_err  out  1  one-cycle pulse when a start is rejected.
- op_sig  out  OP_SIG_WIDTH  operation code broadcast to all PEs.
- arr_clr  out  1  one-cycle clear of PE accumulators (drives PE reset).
- wgt_rd_en  out  1  weight buffer read strobe.
- wgt_rd_addr  out  CNT_WIDTH  weight buffer read address.
- act_rd_en  out  1  activation buffer read strobe.
- act_rd_addr  out  CNT_WIDTH  activation buffer read address.
- res_wr_en  out  1  result buffer write strobe.
- res_wr_addr  out  CNT_WIDTH  result buffer write address.
- perf_cycles  out  32  busy-cycle counter (see Optional Feature).

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE; op_sig = 3'b111 (HOLD); every strobe, busy, done, cfg_err and arr_clr = 0; every address = 0; perf_cycles = 0.
- Operation codes: W_LOAD = 001, W_FLOW = 000, OS_FLOW = 100, OS_DRAIN = 110, HOLD = 111. HOLD is an unmatched code, so PEs keep their state.
- Define F = k_len + ROWS + COLS - 2 (fill plus drain of the skewed wavefront). F is computed at CNT_WIDTH+1 bits; no overflow is allowed.
- Accepted start: start = 1 in IDLE with k_len != 0. mode and k_len are latched; the first non-HOLD output appears in the next cycle (latency 1).
- Rejected start: start = 1 in IDLE with k_len == 0. cfg_err pulses for 1 cycle; the controller stays in IDLE and done is not asserted.
- start while busy is ignored; no queueing.
- IDLE: op_sig = HOLD; all strobes low.
- WLOAD (WS only), ROWS cycles, i = 0..ROWS-1:
  - op_sig = W_LOAD.
  - wgt_rd_en = 1; wgt_rd_addr = i.
- WFLOW (WS), F cycles, i = 0..F-1:
  - op_sig = W_FLOW.
  - act_rd_en = 1 for i < k_len; act_rd_addr = i.
  - res_wr_en = 1 for i >= ROWS+COLS-2; res_wr_addr = i-(ROWS+COLS-2).
- OSCLR (OS only), 1 cycle: arr_clr = 1; op_sig = HOLD.
- OSFLOW, F cycles, i = 0..F-1:
  - op_sig = OS_FLOW.
  - act_rd_en = wgt_rd_en = 1 for i < k_len; both addresses = i.
- OSDRAIN, ROWS cycles, i = 0..ROWS-1:
  - op_sig = OS_DRAIN.
  - res_wr_en = 1; res_wr_addr = i (row select).
- DONE, 1 cycle: done = 1; op_sig = HOLD; next state IDLE. A start in the cycle after DONE is accepted normally.
- Transitions: IDLE->WLOAD->WFLOW->DONE (mode 0); IDLE->OSCLR->OSFLOW->OSDRAIN->DONE (mode 1).
- Strobes fall to 0 in the cycle the owning state is left; addresses hold their last value while the strobe is low.
- reset asserted mid-job: the next cycle shows the full reset state. No done pulse is produced and the partial job is abandoned.

Optional Feature:
- Macro: SA_CTRL_PERF_CNT_EN.
- Defined:
  - perf_cycles clears to 0 on an accepted start.
  - It increments every cycle busy = 1, saturating at 32'hFFFFFFFF.
  - It holds its value in IDLE until the next accepted start.
- Not defined: perf_cycles is tied to 0; the port remains present.

Test Plan (ROWS = COLS = 4; start pulsed in cycle 0):
- WS, k_len = 5 -> WLOAD cycles 1-4 with wgt_rd_addr 0..3; WFLOW cycles 5-15 with act_rd_en cycles 5-9 (addr 0..4) and res_wr_en cycles 11-15 (addr 0..4); done = 1 in cycle 16 only; busy = 1 in cycles 1-16.
- OS, k_len = 5 -> arr_clr in cycle 1; OS_FLOW cycles 2-12 with act/wgt_rd_en cycles 2-6; OS_DRAIN cycles 13-16 with res_wr_addr 0..3; done in cycle 17.
- k_len = 0, start -> cfg_err = 1 in cycle 1; busy stays 0; op_sig stays 111; no done.
- WS job with reset asserted in cycle 7 -> cycle 8 shows op_sig 111, all strobes 0, busy 0; no done. A new start in cycle 9 runs to completion correctly.
- start held high through a WS k_len = 1 job -> the job ends with done; a second job is accepted in the cycle after DONE. start pulses during busy have no effect.
- SA_CTRL_PERF_CNT_EN defined, WS k_len = 5 -> perf_cycles = 16 after done and stays 16 in IDLE. Macro undefined -> perf_cycles = 0 throughout.

Source files
------------

// File: rtl/sa_ctrl.sv
// sa_ctrl: systolic array sequencer (WS/OS dataflows); define SA_CTRL_PERF_CNT_EN to enable the busy-cycle counter
module sa_ctrl #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int CNT_WIDTH    = 8,
  parameter int OP_SIG_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [CNT_WIDTH-1:0]    k_len,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [OP_SIG_WIDTH-1:0] op_sig,
  output logic                    arr_clr,
  output logic                    wgt_rd_en,
  output logic [CNT_WIDTH-1:0]    wgt_rd_addr,
  output logic                    act_rd_en,
  output logic [CNT_WIDTH-1:0]    act_rd_addr,
  output logic                    res_wr_en,
  output logic [CNT_WIDTH-1:0]    res_wr_addr,
  output logic [31:0]             perf_cycles
);
  typedef enum logic [2:0] {IDLE, WLOAD, WFLOW, OSCLR, OSFLOW, OSDRAIN, DONE} state_t;
  localparam logic [CNT_WIDTH:0] SKEW = (CNT_WIDTH+1)'(ROWS + COLS - 2);
  localparam logic [CNT_WIDTH:0] F_OFF = (CNT_WIDTH+1)'(ROWS + COLS - 3);
  localparam logic [CNT_WIDTH:0] ROW_LAST = (CNT_WIDTH+1)'(ROWS - 1);
  localparam logic [OP_SIG_WIDTH-1:0] OP_W_LOAD = OP_SIG_WIDTH'(3'b001);
  localparam logic [OP_SIG_WIDTH-1:0] OP_W_FLOW = OP_SIG_WIDTH'(3'b000);
  localparam logic [OP_SIG_WIDTH-1:0] OP_OS_FLOW = OP_SIG_WIDTH'(3'b100);
  localparam logic [OP_SIG_WIDTH-1:0] OP_OS_DRAIN = OP_SIG_WIDTH'(3'b110);
  localparam logic [OP_SIG_WIDTH-1:0] OP_HOLD = OP_SIG_WIDTH'(3'b111);
  state_t state_q, state_d;
  logic [CNT_WIDTH:0] cnt_q, cnt_d, f_last;
  logic [CNT_WIDTH-1:0] k_q, k_d;
  logic accept, in_k;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, clr_q, clr_d;
  logic wgt_en_q, wgt_en_d, act_en_q, act_en_d, res_en_q, res_en_d;
  logic [OP_SIG_WIDTH-1:0] op_q, op_d;
  logic [CNT_WIDTH-1:0] wgt_addr_q, wgt_addr_d, act_addr_q, act_addr_d, res_addr_q, res_addr_d;
  // next state and in-state index, then outputs decoded from the next state so they register with it
  always_comb begin
    accept = state_q == IDLE && start && k_len != '0;
    k_d = accept ? k_len : k_q;
    f_last = {1'b0, k_q} + F_OFF;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (mode ? OSCLR : WLOAD) : IDLE;
      WLOAD:   state_d = cnt_q == ROW_LAST ? WFLOW : WLOAD;
      WFLOW:   state_d = cnt_q == f_last ? DONE : WFLOW;
      OSCLR:   state_d = OSFLOW;
      OSFLOW:  state_d = cnt_q == f_last ? OSDRAIN : OSFLOW;
      OSDRAIN: state_d = cnt_q == ROW_LAST ? DONE : OSDRAIN;
      default: state_d = IDLE;
    endcase
    cnt_d = state_d == state_q ? cnt_q + (CNT_WIDTH+1)'(1) : '0;
    in_k = cnt_d < {1'b0, k_q};
    op_d = state_d == WLOAD ? OP_W_LOAD :
           state_d == WFLOW ? OP_W_FLOW :
           state_d == OSFLOW ? OP_OS_FLOW :
           state_d == OSDRAIN ? OP_OS_DRAIN : OP_HOLD;
    wgt_en_d = state_d == WLOAD || (state_d == OSFLOW && in_k);
    act_en_d = (state_d == WFLOW || state_d == OSFLOW) && in_k;
    res_en_d = (state_d == WFLOW && cnt_d >= SKEW) || state_d == OSDRAIN;
    wgt_addr_d = wgt_en_d ? CNT_WIDTH'(cnt_d) : wgt_addr_q;
    act_addr_d = act_en_d ? CNT_WIDTH'(cnt_d) : act_addr_q;
    res_addr_d = res_en_d ? CNT_WIDTH'(state_d == WFLOW ? cnt_d - SKEW : cnt_d) : res_addr_q;
    clr_d = state_d == OSCLR;
    done_d = state_d == DONE;
    busy_d = state_d != IDLE;
    err_d = state_q == IDLE && start && k_len == '0;
  end
  // state, job length and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      k_q <= '0;
      op_q <= OP_HOLD;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      clr_q <= 1'b0;
      wgt_en_q <= 1'b0;
      act_en_q <= 1'b0;
      res_en_q <= 1'b0;
      wgt_addr_q <= '0;
      act_addr_q <= '0;
      res_addr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      k_q <= k_d;
      op_q <= op_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      clr_q <= clr_d;
      wgt_en_q <= wgt_en_d;
      act_en_q <= act_en_d;
      res_en_q <= res_en_d;
      wgt_addr_q <= wgt_addr_d;
      act_addr_q <= act_addr_d;
      res_addr_q <= res_addr_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign cfg_err = err_q;
  assign op_sig = op_q;
  assign arr_clr = clr_q;
  assign wgt_rd_en = wgt_en_q;
  assign wgt_rd_addr = wgt_addr_q;
  assign act_rd_en = act_en_q;
  assign act_rd_addr = act_addr_q;
  assign res_wr_en = res_en_q;
  assign res_wr_addr = res_addr_q;
`ifdef SA_CTRL_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;
  // restart on accepted start, count busy cycles, saturate at all-ones
  always_comb perf_d = accept ? '0 : (busy_q && perf_q != '1) ? perf_q + 32'd1 : perf_q;
  // busy-cycle counter register
  always_ff @(posedge clk) perf_q <= reset ? '0 : perf_d;
  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif
endmodule
